// File: rtl/reg_display_scan_ctrl_pkg.sv
// Shared definitions for the register display scan path: conversion FSM states,
// digit index constants, and the active-low hex glyph table.
package reg_display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_COMMIT  = 2'd3
    } conv_state_t;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_ADDR  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        for (int i = 0; i < 3; i++) begin
            res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? (bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_display_scan_ctrl_bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter; carries a tag (the source
// address) alongside the data so the result and its origin commit together.
module bin2bcd_seq
    import reg_display_scan_ctrl_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       bin,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd,
    output logic [TAG_W-1:0] tag_out
);

    conv_state_t      r_state;
    logic [7:0]       r_shift;
    logic [11:0]      r_bcd;
    logic [2:0]       r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic             r_busy;
    logic             r_done;
    logic [11:0]      w_bcd_adj;

    assign w_bcd_adj = bcd_adjust(r_bcd);

    // Conversion FSM; a start seen in COMMIT chains straight into the next CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= 8'd0;
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
            r_tag   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_shift <= bin;
                    r_tag   <= tag_in;
                    r_bcd   <= 12'd0;
                    r_cnt   <= 3'd0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_bcd   <= {w_bcd_adj[10:0], r_shift[7]};
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_COMMIT;
                        r_done  <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd     = r_bcd;
    assign tag_out = r_tag;

endmodule

// File: rtl/reg_display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner for the register bank read port:
// address browse, BCD conversion requests and the digit/segment mux.
module reg_display_scan_ctrl
    import reg_display_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DWELL_TICKS = 1000,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              auto_en,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              conv_busy
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DWELL_TICKS + 1);

    logic [PW-1:0]     r_presc;
    logic [1:0]        r_idx;
    logic [DW-1:0]     r_dwell;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_pending;
    logic [11:0]       r_shown_bcd;
    logic [ADDR_W-1:0] r_shown_addr;
    logic              r_shown_valid;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;

    logic              w_tick;
    logic [1:0]        w_idx_next;
    logic              w_dwell_end;
    logic              w_addr_inc;
    logic              w_req;
    logic              w_start;
    logic              w_busy;
    logic              w_done;
    logic              w_eng_ready;
    logic [11:0]       w_bcd;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [11:0]       w_bcd_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic              w_valid_next;
    logic [3:0]        w_digit;

    assign w_tick      = (r_presc == PW'(CLK_DIV - 1));
    assign w_idx_next  = w_tick ? (r_idx + 2'd1) : r_idx;
    assign w_dwell_end = w_tick && (r_dwell == DW'(DWELL_TICKS - 1));
    assign w_addr_inc  = auto_en ? w_dwell_end : step;
    assign w_req       = (w_tick && (r_idx == DIG_ADDR)) || w_addr_inc;
    assign w_start     = w_req || r_pending;
    assign w_eng_ready = !w_busy || w_done;

    // Prescaler, digit index, dwell counter and read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_idx     <= DIG_UNITS;
            r_dwell   <= '0;
            r_rd_addr <= '0;
        end else begin
            r_presc <= w_tick ? '0 : (r_presc + PW'(1));
            r_idx   <= w_idx_next;
            if (!auto_en) begin
                r_dwell <= '0;
            end else if (w_dwell_end) begin
                r_dwell <= '0;
            end else if (w_tick) begin
                r_dwell <= r_dwell + DW'(1);
            end
            if (w_addr_inc) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
        end
    end

    // A request the engine cannot take right now collapses into one pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else if (w_start && w_eng_ready) begin
            r_pending <= 1'b0;
        end else if (w_req) begin
            r_pending <= 1'b1;
        end
    end

    bin2bcd_seq #(
        .TAG_W (ADDR_W)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .bin     (rd_data),
        .tag_in  (r_rd_addr),
        .busy    (w_busy),
        .done    (w_done),
        .bcd     (w_bcd),
        .tag_out (w_cap_addr)
    );

    // Segment data is chosen from next-cycle index and values so a COMMIT
    // coinciding with a scan tick shows the fresh digit immediately.
    assign w_bcd_sel    = w_done ? w_bcd : r_shown_bcd;
    assign w_addr_sel   = w_done ? w_cap_addr : r_shown_addr;
    assign w_valid_next = r_shown_valid || w_done;

    // Digit value for the index that becomes active on the next clock.
    always_comb begin
        w_digit = 4'd0;
        case (w_idx_next)
            DIG_UNITS: w_digit = w_bcd_sel[3:0];
            DIG_TENS:  w_digit = w_bcd_sel[7:4];
            DIG_HUNDS: w_digit = w_bcd_sel[11:8];
            DIG_ADDR:  w_digit = 4'(w_addr_sel);
            default:   w_digit = 4'd0;
        endcase
    end

    // Committed display values and registered anode/segment drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shown_bcd   <= 12'd0;
            r_shown_addr  <= '0;
            r_shown_valid <= 1'b0;
            r_an          <= 4'b1111;
            r_seg         <= SEG_BLANK;
        end else begin
            if (w_done) begin
                r_shown_bcd   <= w_bcd;
                r_shown_addr  <= w_cap_addr;
                r_shown_valid <= 1'b1;
            end
            if (w_valid_next) begin
                r_an  <= ~(4'b0001 << w_idx_next);
                r_seg <= hex_to_seg(w_digit);
            end else begin
                r_an  <= 4'b1111;
                r_seg <= SEG_BLANK;
            end
        end
    end

    assign rd_addr   = r_rd_addr;
    assign an        = r_an;
    assign seg       = r_seg;
    assign conv_busy = w_busy;

endmodule

// File: tb/tb_reg_display_scan_ctrl.sv
// Directed bench for reg_display_scan_ctrl with CLK_DIV=4, DWELL_TICKS=2.
module tb_reg_display_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       auto_en;
    logic       step;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] an;
    logic [6:0] seg;
    logic       conv_busy;

    logic       ovr_en;
    logic [7:0] ovr_val;

    int checks;
    int passes;

    // Register bank model: address 0 holds 255, others hold {addr,addr}.
    assign rd_data = ovr_en ? ovr_val : ((rd_addr == 4'd0) ? 8'd255 : {rd_addr, rd_addr});

    reg_display_scan_ctrl #(
        .CLK_DIV     (4),
        .DWELL_TICKS (2),
        .ADDR_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .auto_en   (auto_en),
        .step      (step),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .an        (an),
        .seg       (seg),
        .conv_busy (conv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] val);
        for (int i = 0; i < 64 && an !== val; i++) cyc(1);
    endtask

    task automatic wait_busy(input logic val);
        for (int i = 0; i < 64 && conv_busy !== val; i++) cyc(1);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        int blank_bad;
        rst = 1'b1;
        cyc(3);
        checks++;
        if (rd_addr !== 4'd0 || an !== 4'b1111 || seg !== 7'b1111111 || conv_busy !== 1'b0)
            $display("FAIL reset: addr=%h an=%b seg=%b busy=%b want 0/1111/1111111/0", rd_addr, an, seg, conv_busy);
        else passes++;
        rst = 1'b0;
        blank_bad = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (an !== 4'b1111 || seg !== 7'b1111111) blank_bad++;
        end
        checks++;
        if (blank_bad != 0) $display("FAIL blank_before_commit: %0d non-blank cycles want 0", blank_bad);
        else passes++;
    endtask

    task automatic test_convert_255();
        int n;
        wait_busy(1'b1);
        n = 0;
        while (conv_busy === 1'b1 && n < 30) begin
            n++;
            cyc(1);
        end
        checks++;
        if (n != 10) $display("FAIL busy_length: got %0d cycles want 10", n);
        else passes++;
        checks++;
        if (an !== 4'b1011 || seg !== 7'b0100100)
            $display("FAIL glyph_at_cycle10: an=%b seg=%b want 1011/0100100", an, seg);
        else passes++;
        wait_an(4'b0111);
        checks++;
        if (an !== 4'b0111 || seg !== 7'b1000000) $display("FAIL addr_digit_0: an=%b seg=%b want 0111/1000000", an, seg);
        else passes++;
        wait_an(4'b1110);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0010010) $display("FAIL units_5: an=%b seg=%b want 1110/0010010", an, seg);
        else passes++;
        wait_an(4'b1101);
        checks++;
        if (an !== 4'b1101 || seg !== 7'b0010010) $display("FAIL tens_5: an=%b seg=%b want 1101/0010010", an, seg);
        else passes++;
    endtask

    task automatic test_manual_wrap();
        for (int i = 0; i < 15; i++) pulse_step();
        cyc(40);
        wait_an(4'b0111);
        checks++;
        if (rd_addr !== 4'd15 || an !== 4'b0111 || seg !== 7'b0001110)
            $display("FAIL addr_digit_F: addr=%h an=%b seg=%b want f/0111/0001110", rd_addr, an, seg);
        else passes++;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        checks++;
        if (rd_addr !== 4'd0) $display("FAIL manual_wrap: addr=%h want 0", rd_addr);
        else passes++;
        cyc(40);
        wait_an(4'b0111);
        checks++;
        if (an !== 4'b0111 || seg !== 7'b1000000) $display("FAIL addr_digit_after_wrap: an=%b seg=%b want 0111/1000000", an, seg);
        else passes++;
    endtask

    task automatic test_data_change();
        wait_busy(1'b0);
        ovr_en  = 1'b1;
        ovr_val = 8'd42;
        wait_busy(1'b1);
        cyc(3);
        ovr_val = 8'd99;
        wait_busy(1'b0);
        wait_an(4'b1110);
        checks++;
        if (seg !== 7'b0100100 || an !== 4'b1110) $display("FAIL units_2_of_42: an=%b seg=%b want 1110/0100100", an, seg);
        else passes++;
        wait_an(4'b1101);
        checks++;
        if (seg !== 7'b0011001 || an !== 4'b1101) $display("FAIL tens_4_of_42: an=%b seg=%b want 1101/0011001", an, seg);
        else passes++;
        wait_an(4'b1011);
        checks++;
        if (seg !== 7'b1000000 || an !== 4'b1011) $display("FAIL hunds_0_of_42: an=%b seg=%b want 1011/1000000", an, seg);
        else passes++;
        wait_busy(1'b1);
        wait_busy(1'b0);
        wait_an(4'b1110);
        checks++;
        if (seg !== 7'b0010000 || an !== 4'b1110) $display("FAIL units_9_of_99: an=%b seg=%b want 1110/0010000", an, seg);
        else passes++;
        wait_an(4'b1101);
        checks++;
        if (seg !== 7'b0010000 || an !== 4'b1101) $display("FAIL tens_9_of_99: an=%b seg=%b want 1101/0010000", an, seg);
        else passes++;
        wait_an(4'b1011);
        checks++;
        if (seg !== 7'b1000000 || an !== 4'b1011) $display("FAIL hunds_0_of_99: an=%b seg=%b want 1011/1000000", an, seg);
        else passes++;
        ovr_en = 1'b0;
    endtask

    task automatic test_auto_browse();
        logic [3:0] prev;
        int n;
        auto_en = 1'b1;
        prev = rd_addr;
        for (int i = 0; i < 40 && rd_addr === prev; i++) cyc(1);
        for (int k = 0; k < 2; k++) begin
            prev = rd_addr;
            n = 0;
            while (rd_addr === prev && n < 40) begin
                if (k == 1 && n == 2) step = 1'b1;
                else step = 1'b0;
                cyc(1);
                n++;
            end
            step = 1'b0;
            checks++;
            if (n != 8 || rd_addr !== prev + 4'd1)
                $display("FAIL auto_interval_%0d: %0d clocks to addr %h want 8 to %h", k, n, rd_addr, prev + 4'd1);
            else passes++;
        end
        auto_en = 1'b0;
        cyc(1);
        prev = rd_addr;
        pulse_step();
        checks++;
        if (rd_addr !== prev + 4'd1) $display("FAIL manual_after_auto: addr=%h want %h", rd_addr, prev + 4'd1);
        else passes++;
    endtask

    task automatic test_reset_mid_conversion();
        int blank_bad;
        wait_busy(1'b0);
        wait_busy(1'b1);
        cyc(4);
        rst = 1'b1;
        cyc(1);
        checks++;
        if (conv_busy !== 1'b0 || an !== 4'b1111 || seg !== 7'b1111111 || rd_addr !== 4'd0)
            $display("FAIL reset_mid_conv: busy=%b an=%b seg=%b addr=%h want 0/1111/1111111/0", conv_busy, an, seg, rd_addr);
        else passes++;
        rst = 1'b0;
        blank_bad = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            if (an !== 4'b1111 || seg !== 7'b1111111) blank_bad++;
        end
        checks++;
        if (blank_bad != 0) $display("FAIL no_stale_commit: %0d non-blank cycles want 0", blank_bad);
        else passes++;
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        rst     = 1'b1;
        auto_en = 1'b0;
        step    = 1'b0;
        ovr_en  = 1'b0;
        ovr_val = 8'd0;
        #1;
        test_reset();
        test_convert_255();
        test_manual_wrap();
        test_data_change();
        test_auto_browse();
        test_reset_mid_conversion();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
